// File: rtl/crc_pkg.sv
// Shared constants and types for the streaming CRC checker.
// Imported by crc_step and crc_stream_checker.
package crc_pkg;

  localparam int          CRC_W_DEF = 16;
  localparam logic [15:0] POLY_DEF  = 16'h1021;
  localparam logic [15:0] INIT_DEF  = 16'h0000;

  localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
  localparam logic [15:0] CRC16_IBM_POLY   = 16'h8005;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } crc_state_e;

endpackage

// File: rtl/crc_step.sv
// Combinational MSB-first CRC update over one DATA_W-bit beat.
// Non-reflected, no final XOR.
import crc_pkg::*;

module crc_step #(
  parameter int               CRC_W  = CRC_W_DEF,
  parameter logic [CRC_W-1:0] POLY   = CRC_W'(POLY_DEF),
  parameter int               DATA_W = 8
) (
  input  logic [CRC_W-1:0]  crc_in,
  input  logic [DATA_W-1:0] data,
  output logic [CRC_W-1:0]  crc_out
);

  logic [CRC_W-1:0] c;
  logic             fb;

  always_comb begin
    c  = crc_in;
    fb = 1'b0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = c[CRC_W-1] ^ data[i];
      c  = (c << 1) ^ (fb ? POLY : '0);
    end
    crc_out = c;
  end

endmodule

// File: rtl/crc_stream_checker.sv
// Streaming CRC codeword checker: payload+CRC in, held
// pass/fail, residue and beat count out.
import crc_pkg::*;

module crc_stream_checker #(
  parameter int               CRC_W  = CRC_W_DEF,
  parameter logic [CRC_W-1:0] POLY   = CRC_W'(POLY_DEF),
  parameter logic [CRC_W-1:0] INIT   = CRC_W'(INIT_DEF),
  parameter int               DATA_W = 8,
  parameter int               LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_ok,
  output logic [CRC_W-1:0]  res_crc,
  output logic [LEN_W-1:0]  res_len
);

  crc_state_e       state_q, state_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             vld_q, vld_d;
  logic             ok_q, ok_d;
  logic [CRC_W-1:0] rcrc_q, rcrc_d;
  logic [LEN_W-1:0] rlen_q, rlen_d;

  logic             accept;
  logic             from_init;
  logic [CRC_W-1:0] base_crc;
  logic [LEN_W-1:0] base_len;
  logic [CRC_W-1:0] step_crc;
  logic [LEN_W-1:0] len_inc;
  logic             fin, mid, drop;

  always_comb begin
    in_ready = 1'b1;
    unique case (state_q)
      ST_DONE: in_ready = res_ready;
      default: in_ready = 1'b1;
    endcase
  end

  assign accept = in_valid && in_ready;

  // A beat taken outside RUN always starts a fresh codeword.
  assign from_init = (state_q != ST_RUN);
  assign base_crc  = from_init ? INIT : crc_q;
  assign base_len  = from_init ? '0 : len_q;
  assign len_inc   = (&base_len) ? base_len
                                 : base_len + 1'b1;

  crc_step #(
    .CRC_W  (CRC_W),
    .POLY   (POLY),
    .DATA_W (DATA_W)
  ) u_step (
    .crc_in  (base_crc),
    .data    (in_data),
    .crc_out (step_crc)
  );

  assign fin  = !clr && accept && in_last;
  assign mid  = !clr && accept && !in_last;
  assign drop = !clr && !accept
             && (state_q == ST_DONE) && res_ready;

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    len_d   = len_q;
    vld_d   = vld_q;
    ok_d    = ok_q;
    rcrc_d  = rcrc_q;
    rlen_d  = rlen_q;
    unique case (1'b1)
      clr: begin
        state_d = ST_IDLE;
        crc_d   = INIT;
        len_d   = '0;
        vld_d   = 1'b0;
        ok_d    = 1'b0;
        rcrc_d  = '0;
        rlen_d  = '0;
      end
      fin: begin
        state_d = ST_DONE;
        crc_d   = INIT;
        len_d   = '0;
        vld_d   = 1'b1;
        ok_d    = (step_crc == '0);
        rcrc_d  = step_crc;
        rlen_d  = len_inc;
      end
      mid: begin
        state_d = ST_RUN;
        crc_d   = step_crc;
        len_d   = len_inc;
        vld_d   = 1'b0;
      end
      drop: begin
        state_d = ST_IDLE;
        vld_d   = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      crc_q   <= INIT;
      len_q   <= '0;
      vld_q   <= 1'b0;
      ok_q    <= 1'b0;
      rcrc_q  <= '0;
      rlen_q  <= '0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      len_q   <= len_d;
      vld_q   <= vld_d;
      ok_q    <= ok_d;
      rcrc_q  <= rcrc_d;
      rlen_q  <= rlen_d;
    end
  end

  assign res_valid = vld_q;
  assign res_ok    = ok_q;
  assign res_crc   = rcrc_q;
  assign res_len   = rlen_q;

endmodule
